// File: rtl/semaforo_pkg.sv
// Lamp encodings, FSM states and lamp-bus validity shared by the traffic controller and its front ends.
package semaforo_pkg;

  localparam logic [2:0] LUZ_VERDE    = 3'b001;
  localparam logic [2:0] LUZ_AMARELO  = 3'b010;
  localparam logic [2:0] LUZ_VERMELHO = 3'b100;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    SERVING  = 2'd2,
    COOLDOWN = 2'd3
  } estado_t;

  function automatic logic luz_valida(input logic [2:0] luz);
    return (luz == LUZ_VERDE) || (luz == LUZ_AMARELO) || (luz == LUZ_VERMELHO);
  endfunction

endpackage

// File: rtl/semaforo_pedido_debounce.sv
// Push-button synchronizer and debouncer; the level flips after DEB_CYCLES stable synchronized cycles.
// o_rise is a registered one-cycle pulse on the same edge the debounced level goes high.
module debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      if (r_sync2 != r_level) begin
        if (r_cnt == CW'(DEB_CYCLES - 1)) begin
          r_level <= r_sync2;
          r_rise  <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/semaforo_pedido.sv
// Pedestrian request front end: holds bt until one full red phase of light A is served, then cools down.
// bt is registered; a clean press raises it DEB_CYCLES+2 edges after the button is first sampled high.
module semaforo_pedido
  import semaforo_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int COOL_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_raw,
  input  logic [2:0]       A,
  output logic             bt,
  output logic             req_led,
  output logic             served,
  output logic [CNT_W-1:0] served_cnt,
  output logic             fault
);

  localparam int CCW = $clog2(COOL_CYCLES + 1);

  estado_t          r_state;
  estado_t          w_state_nxt;
  logic [CCW-1:0]   r_cool;
  logic [CCW-1:0]   w_cool_nxt;
  logic             r_pend;
  logic             w_pend_nxt;
  logic             r_bt;
  logic             w_bt_nxt;
  logic             r_served;
  logic             w_served_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fault;
  logic             w_a_ok;
  logic             w_level;
  logic             w_rise;
  logic             w_press;

  debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_btn_raw(btn_raw),
    .o_level  (w_level),
    .o_rise   (w_rise)
  );

  assign w_a_ok  = luz_valida(A);
  assign w_press = w_rise & w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cool   <= '0;
      r_pend   <= 1'b0;
      r_bt     <= 1'b0;
      r_served <= 1'b0;
      r_cnt    <= '0;
      r_fault  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cool   <= w_cool_nxt;
      r_pend   <= w_pend_nxt;
      r_bt     <= w_bt_nxt;
      r_served <= w_served_nxt;
      r_fault  <= r_fault | ~w_a_ok;
      if (w_served_nxt) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // A malformed lamp bus overrides everything, including a SERVING exit in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cool_nxt  = r_cool;
    w_pend_nxt  = r_pend;
    if (r_fault || !w_a_ok) begin
      w_state_nxt = IDLE;
      w_cool_nxt  = '0;
      w_pend_nxt  = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_press) w_state_nxt = ARMED;
        end
        ARMED: begin
          if (A == LUZ_VERMELHO) w_state_nxt = SERVING;
        end
        SERVING: begin
          if (A != LUZ_VERMELHO) begin
            w_state_nxt = COOLDOWN;
            w_cool_nxt  = '0;
          end
        end
        COOLDOWN: begin
          if (r_cool == CCW'(COOL_CYCLES - 1)) begin
            w_state_nxt = (r_pend || w_press) ? ARMED : IDLE;
            w_pend_nxt  = 1'b0;
            w_cool_nxt  = '0;
          end else begin
            w_cool_nxt = r_cool + CCW'(1);
            if (w_press) w_pend_nxt = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    w_bt_nxt     = (w_state_nxt == ARMED) || (w_state_nxt == SERVING);
    w_served_nxt = (r_state == SERVING) && (w_state_nxt == COOLDOWN);
    req_led      = (r_state == ARMED) || (r_state == SERVING) ||
                   ((r_state == COOLDOWN) && r_pend);
  end

  assign bt         = r_bt;
  assign served     = r_served;
  assign served_cnt = r_cnt;
  assign fault      = r_fault;

endmodule

// File: tb/tb_semaforo_pedido.sv
// Bench for semaforo_pedido at default parameters; served pulses are matched against a queue of expected counts.
module tb_semaforo_pedido;
  import semaforo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic [2:0] A = LUZ_VERDE;
  logic       bt;
  logic       req_led;
  logic       served;
  logic [7:0] served_cnt;
  logic       fault;

  int         n_checks = 0;
  int         n_pass = 0;
  int         n_pulses = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] sb[$];

  always #5 clk = ~clk;

  semaforo_pedido #(
    .DEB_CYCLES (4),
    .COOL_CYCLES(8),
    .CNT_W      (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .A         (A),
    .bt        (bt),
    .req_led   (req_led),
    .served    (served),
    .served_cnt(served_cnt),
    .fault     (fault)
  );

  // Scoreboard consumer: every served pulse must match the oldest expected count.
  always @(negedge clk) begin
    if (served === 1'b1) begin
      n_pulses++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected_served: served_cnt=%0d with no expected completion", served_cnt);
      end else begin
        logic [7:0] e;
        e = sb.pop_front();
        if (served_cnt !== e) $display("FAIL sb_served_cnt: got %0d expected %0d", served_cnt, e);
        else n_pass++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_bt_high(input int budget, output bit ok);
    int i;
    i = 0;
    while (bt !== 1'b1 && i < budget) begin
      tick();
      i++;
    end
    ok = (bt === 1'b1);
  endtask

  // Walks light A through green, yellow, red and back to green; the final edge completes the request.
  task automatic drive_serve(input int red_cycles);
    A = LUZ_VERDE;
    tick();
    A = LUZ_AMARELO;
    tick();
    A = LUZ_VERMELHO;
    repeat (red_cycles) tick();
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back(exp_cnt);
    A = LUZ_VERDE;
    tick();
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    tick();
    tick();
    obs = {bt, req_led, served, fault, served_cnt};
    n_checks++;
    if (obs !== 12'd0) $display("FAIL reset_outputs: got %03h expected 000", obs);
    else n_pass++;
    rst_n = 1'b1;
    repeat (3) tick();
    obs = {bt, req_led, served, fault, served_cnt};
    n_checks++;
    if (obs !== 12'd0) $display("FAIL post_reset_idle: got %03h expected 000", obs);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    btn_raw = 1'b1;
    repeat (6) tick();
    n_checks++;
    if (bt !== 1'b0) $display("FAIL press_bt_after_edge5: got %b expected 0", bt);
    else n_pass++;
    tick();
    n_checks++;
    if (bt !== 1'b1 || req_led !== 1'b1) $display("FAIL press_bt_after_edge6: got bt=%b led=%b expected 1/1", bt, req_led);
    else n_pass++;
    btn_raw = 1'b0;
    drive_serve(3);
    n_checks++;
    if (bt !== 1'b0 || served !== 1'b1) $display("FAIL serve_exit: got bt=%b served=%b expected 0/1", bt, served);
    else n_pass++;
    tick();
    n_checks++;
    if (served !== 1'b0 || served_cnt !== exp_cnt) $display("FAIL serve_after: got served=%b cnt=%0d expected 0/%0d", served, served_cnt, exp_cnt);
    else n_pass++;
    n_checks++;
    if (req_led !== 1'b0) $display("FAIL serve_led: got %b expected 0", req_led);
    else n_pass++;
    repeat (12) tick();
  endtask

  task automatic test_bounce();
    btn_raw = 1'b1;
    tick();
    btn_raw = 1'b0;
    tick();
    btn_raw = 1'b1;
    tick();
    btn_raw = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      n_checks++;
      if ({bt, req_led} !== 2'b00) $display("FAIL bounce_cycle%0d: got bt/led=%b%b expected 00", i, bt, req_led);
      else n_pass++;
    end
  endtask

  task automatic test_cooldown_press();
    bit ok;
    int low;
    int hi_cycles;
    btn_raw = 1'b1;
    wait_bt_high(20, ok);
    n_checks++;
    if (!ok) $display("FAIL cool_first_press: bt=%b expected 1 within budget", bt);
    else n_pass++;
    btn_raw = 1'b0;
    repeat (8) tick();
    drive_serve(2);
    btn_raw = 1'b1;
    low = 0;
    while (bt === 1'b0 && low < 20) begin
      low++;
      tick();
    end
    n_checks++;
    if (low !== 8) $display("FAIL cool_low_cycles: got %0d expected 8", low);
    else n_pass++;
    n_checks++;
    if (bt !== 1'b1 || req_led !== 1'b1) $display("FAIL cool_rearm: got bt=%b led=%b expected 1/1", bt, req_led);
    else n_pass++;
    btn_raw = 1'b0;
    repeat (8) tick();
    A = LUZ_VERMELHO;
    tick();
    btn_raw = 1'b1;
    repeat (8) tick();
    exp_cnt = exp_cnt + 8'd1;
    sb.push_back(exp_cnt);
    A = LUZ_VERDE;
    tick();
    btn_raw = 1'b0;
    hi_cycles = 0;
    repeat (20) begin
      tick();
      if (bt !== 1'b0) hi_cycles++;
    end
    n_checks++;
    if (hi_cycles !== 0) $display("FAIL serving_press_absorbed: bt high %0d cycles expected 0", hi_cycles);
    else n_pass++;
    n_checks++;
    if (req_led !== 1'b0 || served_cnt !== exp_cnt) $display("FAIL serving_press_state: led=%b cnt=%0d expected 0/%0d", req_led, served_cnt, exp_cnt);
    else n_pass++;
  endtask

  task automatic test_fault();
    bit ok;
    btn_raw = 1'b1;
    wait_bt_high(20, ok);
    n_checks++;
    if (!ok) $display("FAIL fault_arm: bt=%b expected 1 within budget", bt);
    else n_pass++;
    btn_raw = 1'b0;
    A = 3'b011;
    tick();
    A = LUZ_VERDE;
    n_checks++;
    if (fault !== 1'b1 || bt !== 1'b0) $display("FAIL fault_set: got fault=%b bt=%b expected 1/0", fault, bt);
    else n_pass++;
    repeat (8) tick();
    btn_raw = 1'b1;
    repeat (12) tick();
    n_checks++;
    if ({fault, bt, req_led} !== 3'b100) $display("FAIL fault_sticky_ignore: got fault/bt/led=%b%b%b expected 100", fault, bt, req_led);
    else n_pass++;
    btn_raw = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_cnt = 8'd0;
    n_checks++;
    if (fault !== 1'b0 || served_cnt !== 8'd0) $display("FAIL fault_cleared_by_reset: got fault=%b cnt=%0d expected 0/0", fault, served_cnt);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_serving();
    bit ok;
    logic [11:0] obs;
    int hi_cycles;
    btn_raw = 1'b1;
    wait_bt_high(20, ok);
    btn_raw = 1'b0;
    drive_serve(1);
    repeat (14) tick();
    btn_raw = 1'b1;
    wait_bt_high(20, ok);
    btn_raw = 1'b0;
    A = LUZ_VERMELHO;
    repeat (2) tick();
    n_checks++;
    if (!ok || bt !== 1'b1 || req_led !== 1'b1 || served_cnt !== exp_cnt) $display("FAIL mid_serving_setup: bt=%b led=%b cnt=%0d expected 1/1/%0d", bt, req_led, served_cnt, exp_cnt);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    exp_cnt = 8'd0;
    obs = {bt, req_led, served, fault, served_cnt};
    n_checks++;
    if (obs !== 12'd0) $display("FAIL mid_serving_reset: got %03h expected 000", obs);
    else n_pass++;
    A = LUZ_VERDE;
    tick();
    rst_n = 1'b1;
    hi_cycles = 0;
    repeat (15) begin
      tick();
      if (bt !== 1'b0 || req_led !== 1'b0) hi_cycles++;
    end
    n_checks++;
    if (hi_cycles !== 0) $display("FAIL after_reset_quiet: active %0d cycles expected 0", hi_cycles);
    else n_pass++;
  endtask

  task automatic test_wrap();
    bit ok;
    int timeouts;
    int p0;
    timeouts = 0;
    p0 = n_pulses;
    for (int r = 0; r < 256; r++) begin
      btn_raw = 1'b1;
      wait_bt_high(20, ok);
      if (!ok) timeouts++;
      btn_raw = 1'b0;
      A = LUZ_VERMELHO;
      tick();
      exp_cnt = exp_cnt + 8'd1;
      sb.push_back(exp_cnt);
      A = LUZ_VERDE;
      tick();
      repeat (9) tick();
    end
    n_checks++;
    if (timeouts !== 0) $display("FAIL wrap_press_timeouts: got %0d expected 0", timeouts);
    else n_pass++;
    n_checks++;
    if (served_cnt !== 8'd0) $display("FAIL wrap_count: got %0d expected 0", served_cnt);
    else n_pass++;
    n_checks++;
    if (n_pulses - p0 !== 256) $display("FAIL wrap_pulses: got %0d expected 256", n_pulses - p0);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_cooldown_press();
    test_fault();
    test_reset_mid_serving();
    test_wrap();
    repeat (4) tick();
    n_checks++;
    if (sb.size() !== 0) $display("FAIL sb_leftover: %0d expected completions never seen", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
